// File: rtl/orientation_sequencer_pkg.sv
// Shared types and constants for the rover heading measurement sequencer.
package orientation_sequencer_pkg;

    localparam int R_W      = 8;
    localparam int THETA_W  = 4;
    localparam int ORIENT_W = 5;
    localparam int LOC_W    = THETA_W + R_W;
    localparam int CLK_HZ   = 27_000_000;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MEAS0     = 3'd1,
        S_MOVE      = 3'd2,
        S_SETTLE    = 3'd3,
        S_MEAS1     = 3'd4,
        S_CHECK     = 3'd5,
        S_CALC      = 3'd6,
        S_WAIT_MATH = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'b00,
        ERR_MEAS_TIMEOUT = 2'b01,
        ERR_MATH_TIMEOUT = 2'b10,
        ERR_NO_MOVE      = 2'b11
    } err_code_t;

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter. Loading N raises expired during the N-th cycle after
// the load edge, so a state that waits on expired leaves exactly N edges later.
// A load value of 0 behaves like 1.
module interval_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload, else count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (load_value == '0) ? CNT_W'(1) : load_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/orientation_sequencer.sv
// Sequences one heading measurement: fix, drive forward, settle, second fix,
// then hand both fixes to orientation_math and latch its heading.
// Valid/ready note: there is no backpressure here. sweep_req and math_enable
// are single-cycle requests; loc_valid and math_done are single-cycle
// responses that are only accepted in the state waiting for them.
module orientation_sequencer
    import orientation_sequencer_pkg::*;
#(
    parameter int MOVE_CYCLES    = CLK_HZ / 2,
    parameter int SETTLE_CYCLES  = CLK_HZ / 4,
    parameter int TIMEOUT_CYCLES = CLK_HZ,
    parameter int CNT_W          = 25
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic                loc_valid,
    input  logic [LOC_W-1:0]    loc_r_theta,
    output logic                sweep_req,
    output logic                move_fwd,
    output logic [LOC_W-1:0]    math_r_theta_original,
    output logic [LOC_W-1:0]    math_r_theta_final,
    output logic                math_enable,
    input  logic                math_done,
    input  logic [ORIENT_W-1:0] math_orientation,
    output logic                busy,
    output logic                done,
    output logic [ORIENT_W-1:0] orientation,
    output logic                orientation_valid,
    output logic                error,
    output logic [1:0]          error_code,
    output state_t              state_dbg
);

    state_t                state_q, state_d;
    logic                  sweep_req_q, sweep_req_d;
    logic                  move_fwd_q, move_fwd_d;
    logic                  math_enable_q, math_enable_d;
    logic                  done_q, done_d;
    logic [LOC_W-1:0]      orig_q, orig_d;
    logic [LOC_W-1:0]      final_q, final_d;
    logic [ORIENT_W-1:0]   orient_q, orient_d;
    logic                  orient_valid_q, orient_valid_d;
    logic                  error_q, error_d;
    err_code_t             err_code_q, err_code_d;

    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_value;
    logic                  tmr_expired;

    interval_timer #(.CNT_W(CNT_W)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .expired    (tmr_expired)
    );

    // Next-state and next-output logic; every output is registered, so the
    // pulse that belongs to a transition appears in the cycle after it.
    always_comb begin
        state_d        = state_q;
        sweep_req_d    = 1'b0;
        math_enable_d  = 1'b0;
        done_d         = 1'b0;
        move_fwd_d     = move_fwd_q;
        orig_d         = orig_q;
        final_d        = final_q;
        orient_d       = orient_q;
        orient_valid_d = orient_valid_q;
        error_d        = error_q;
        err_code_d     = err_code_q;
        tmr_load       = 1'b0;
        tmr_value      = '0;

        if (abort) begin
            // Cancel leaves results and error flags untouched.
            state_d    = S_IDLE;
            move_fwd_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d        = S_MEAS0;
                        error_d        = 1'b0;
                        err_code_d     = ERR_NONE;
                        orient_valid_d = 1'b0;
                        sweep_req_d    = 1'b1;
                        tmr_load       = 1'b1;
                        tmr_value      = CNT_W'(TIMEOUT_CYCLES);
                    end
                end
                S_MEAS0: begin
                    if (loc_valid) begin
                        orig_d     = loc_r_theta;
                        state_d    = S_MOVE;
                        move_fwd_d = 1'b1;
                        tmr_load   = 1'b1;
                        tmr_value  = CNT_W'(MOVE_CYCLES);
                    end else if (tmr_expired) begin
                        state_d    = S_IDLE;
                        error_d    = 1'b1;
                        err_code_d = ERR_MEAS_TIMEOUT;
                    end
                end
                S_MOVE: begin
                    if (tmr_expired) begin
                        state_d    = S_SETTLE;
                        move_fwd_d = 1'b0;
                        tmr_load   = 1'b1;
                        tmr_value  = CNT_W'(SETTLE_CYCLES);
                    end
                end
                S_SETTLE: begin
                    if (tmr_expired) begin
                        state_d     = S_MEAS1;
                        sweep_req_d = 1'b1;
                        tmr_load    = 1'b1;
                        tmr_value   = CNT_W'(TIMEOUT_CYCLES);
                    end
                end
                S_MEAS1: begin
                    if (loc_valid) begin
                        final_d = loc_r_theta;
                        state_d = S_CHECK;
                    end else if (tmr_expired) begin
                        state_d    = S_IDLE;
                        error_d    = 1'b1;
                        err_code_d = ERR_MEAS_TIMEOUT;
                    end
                end
                S_CHECK: begin
                    // Identical fixes mean the rover did not move; no heading exists.
                    if (final_q == orig_q) begin
                        state_d    = S_IDLE;
                        error_d    = 1'b1;
                        err_code_d = ERR_NO_MOVE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    state_d       = S_WAIT_MATH;
                    math_enable_d = 1'b1;
                    tmr_load      = 1'b1;
                    tmr_value     = CNT_W'(TIMEOUT_CYCLES);
                end
                S_WAIT_MATH: begin
                    // A result arriving on the expiry cycle still counts.
                    if (math_done) begin
                        orient_d       = math_orientation;
                        orient_valid_d = 1'b1;
                        done_d         = 1'b1;
                        state_d        = S_IDLE;
                    end else if (tmr_expired) begin
                        state_d    = S_IDLE;
                        error_d    = 1'b1;
                        err_code_d = ERR_MATH_TIMEOUT;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    move_fwd_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset clears move_fwd without a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            sweep_req_q    <= 1'b0;
            move_fwd_q     <= 1'b0;
            math_enable_q  <= 1'b0;
            done_q         <= 1'b0;
            orig_q         <= '0;
            final_q        <= '0;
            orient_q       <= '0;
            orient_valid_q <= 1'b0;
            error_q        <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            sweep_req_q    <= sweep_req_d;
            move_fwd_q     <= move_fwd_d;
            math_enable_q  <= math_enable_d;
            done_q         <= done_d;
            orig_q         <= orig_d;
            final_q        <= final_d;
            orient_q       <= orient_d;
            orient_valid_q <= orient_valid_d;
            error_q        <= error_d;
            err_code_q     <= err_code_d;
        end
    end

    assign sweep_req             = sweep_req_q;
    assign move_fwd              = move_fwd_q;
    assign math_enable           = math_enable_q;
    assign done                  = done_q;
    assign math_r_theta_original = orig_q;
    assign math_r_theta_final    = final_q;
    assign orientation           = orient_q;
    assign orientation_valid     = orient_valid_q;
    assign error                 = error_q;
    assign error_code            = err_code_q;
    assign busy                  = (state_q != S_IDLE);
    assign state_dbg             = state_q;

endmodule

// File: tb/tb_orientation_sequencer.sv
// Testbench for orientation_sequencer with a behavioural orientation_math
// responder whose latency and result are set per run.
module tb_orientation_sequencer;
    import orientation_sequencer_pkg::*;

    localparam int MOVE   = 4;
    localparam int SETTLE = 3;
    localparam int TMO    = 20;
    localparam int NEVER  = 200;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        loc_valid = 1'b0;
    logic [11:0] loc_r_theta = '0;
    logic        math_done = 1'b0;
    logic [4:0]  math_orientation = '0;

    logic        sweep_req, move_fwd, math_enable, busy, done;
    logic        orientation_valid, error;
    logic [11:0] math_r_theta_original, math_r_theta_final;
    logic [4:0]  orientation;
    logic [1:0]  error_code;
    state_t      state_dbg;

    always #5 clock = ~clock;

    orientation_sequencer #(
        .MOVE_CYCLES    (MOVE),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (25)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .start                 (start),
        .abort                 (abort),
        .loc_valid             (loc_valid),
        .loc_r_theta           (loc_r_theta),
        .sweep_req             (sweep_req),
        .move_fwd              (move_fwd),
        .math_r_theta_original (math_r_theta_original),
        .math_r_theta_final    (math_r_theta_final),
        .math_enable           (math_enable),
        .math_done             (math_done),
        .math_orientation      (math_orientation),
        .busy                  (busy),
        .done                  (done),
        .orientation           (orientation),
        .orientation_valid     (orientation_valid),
        .error                 (error),
        .error_code            (error_code),
        .state_dbg             (state_dbg)
    );

    // ---------------- vector record ----------------
    typedef struct {
        logic [11:0] v0;
        int          d0;
        logic [11:0] v1;
        int          d1;
        int          lat;
        logic [4:0]  ret;
        int          mode;       // 0 plain, 1 start pulsed in SETTLE, 2 abort in MEAS1
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [4:0]  exp_orient;
        logic        exp_valid;
        int          exp_moves;
        int          exp_en;
    } vec_t;

    int          total_cnt = 0;
    int          bad_cnt = 0;
    logic [4:0]  exp_q[$];
    logic [4:0]  model_orient = '0;

    int          math_lat = 0;
    logic [4:0]  math_ret = '0;
    bit          stub_busy = 1'b0;

    // ---------------- monitor (event counters and time stamps) ----------------
    int   cyc = 0, sweep_n = 0, move_n = 0, en_n = 0, done_n = 0;
    int   sweep_t = 0, en_t = 0, err_t = 0, move_fall_t = 0;
    logic move_prev = 1'b0, err_prev = 1'b0;
    logic [4:0] done_o = '0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (sweep_req) begin sweep_n = sweep_n + 1; sweep_t = cyc; end
        if (move_fwd) move_n = move_n + 1;
        if (move_prev && !move_fwd) move_fall_t = cyc;
        move_prev = move_fwd;
        if (math_enable) begin en_n = en_n + 1; en_t = cyc; end
        if (done) begin done_n = done_n + 1; done_o = orientation; end
        if (error && !err_prev) err_t = cyc;
        err_prev = error;
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // orientation_math stand-in: answers math_lat cycles after math_enable.
    initial begin
        forever begin
            tick();
            if (math_enable) begin
                stub_busy = 1'b1;
                if (math_lat < 100) begin
                    repeat (math_lat) tick();
                    math_orientation = math_ret;
                    math_done = 1'b1;
                    tick();
                    math_done = 1'b0;
                    math_orientation = 5'($urandom);
                end
                stub_busy = 1'b0;
            end
        end
    end

    // Wait for a sweep request; gives up if the DUT falls idle or stalls.
    task automatic wait_sweep(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (sweep_req) begin ok = 1'b1; return; end
            if (!busy) return;
            tick();
        end
    endtask

    task automatic drive_loc(input logic [11:0] v, input int d);
        repeat (d) tick();
        loc_r_theta = v;
        loc_valid = 1'b1;
        tick();
        loc_valid = 1'b0;
        loc_r_theta = 12'($urandom);
    endtask

    function automatic vec_t mk(logic [11:0] v0, int d0, logic [11:0] v1, int d1,
                                int lat, logic [4:0] ret, int mode, logic err,
                                logic [1:0] code, logic [4:0] o, logic val,
                                int mv, int en);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.lat = lat; v.ret = ret;
        v.mode = mode; v.exp_err = err; v.exp_code = code; v.exp_orient = o;
        v.exp_valid = val; v.exp_moves = mv; v.exp_en = en;
        return v;
    endfunction

    // Reference outcome of a plain run, from the run rules: each wait for a
    // fix or a result allows a response within TMO cycles of its request.
    function automatic vec_t model(vec_t v);
        vec_t r = v;
        r.exp_err = 1'b1; r.exp_code = 2'b00; r.exp_orient = model_orient;
        r.exp_valid = 1'b0; r.exp_moves = 0; r.exp_en = 0;
        if (v.d0 >= TMO) begin r.exp_code = 2'b01; return r; end
        r.exp_moves = MOVE;
        if (v.d1 >= TMO) begin r.exp_code = 2'b01; return r; end
        if (v.v1 == v.v0) begin r.exp_code = 2'b11; return r; end
        r.exp_en = 1;
        if (v.lat >= TMO) begin r.exp_code = 2'b10; return r; end
        r.exp_err = 1'b0;
        r.exp_orient = v.ret;
        r.exp_valid = 1'b1;
        return r;
    endfunction

    function automatic int pick_delay();
        case ($urandom_range(0, 11))
            0:       return TMO - 1;
            1:       return TMO;
            2:       return TMO + 2;
            default: return $urandom_range(0, 8);
        endcase
    endfunction

    // ---------------- one full run with scoreboard ----------------
    task automatic run_case(input int idx, input vec_t v);
        int  m0, e0, d0c, t, sw2_t;
        bit  ok;
        m0 = move_n; e0 = en_n; d0c = done_n; sw2_t = -1;
        math_lat = v.lat;
        math_ret = v.ret;
        if (v.exp_valid) exp_q.push_back(v.exp_orient);

        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sweep(ok);
        check($sformatf("r%0d_first_sweep", idx), int'(ok), 1);
        if (ok) begin
            drive_loc(v.v0, v.d0);
            if (v.mode == 1) begin
                t = 0;
                while (!((move_n - m0) > 0 && !move_fwd) && t < 60) begin tick(); t++; end
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            wait_sweep(ok);
            if (ok) begin
                sw2_t = cyc;
                if (v.mode == 2) begin
                    tick(); tick();
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                end else begin
                    drive_loc(v.v1, v.d1);
                end
            end
        end

        t = 0;
        while (busy && t < 200) begin tick(); t++; end
        check($sformatf("r%0d_idle_reached", idx), int'(busy), 0);
        t = 0;
        while (stub_busy && t < 200) begin tick(); t++; end
        tick(); tick();

        check($sformatf("r%0d_error", idx), error, v.exp_err);
        check($sformatf("r%0d_error_code", idx), error_code, v.exp_code);
        check($sformatf("r%0d_orientation", idx), orientation, v.exp_orient);
        check($sformatf("r%0d_orient_valid", idx), orientation_valid, v.exp_valid);
        check($sformatf("r%0d_done_pulses", idx), done_n - d0c, v.exp_valid ? 1 : 0);
        check($sformatf("r%0d_move_cycles", idx), move_n - m0, v.exp_moves);
        check($sformatf("r%0d_math_enables", idx), en_n - e0, v.exp_en);
        check($sformatf("r%0d_state_idle", idx), state_dbg, S_IDLE);
        if (done_n != d0c && exp_q.size() > 0)
            check($sformatf("r%0d_orient_at_done", idx), done_o, exp_q.pop_front());
        check($sformatf("r%0d_pending_results", idx), exp_q.size(), 0);
        exp_q.delete();
        if (v.exp_code == 2'b10)
            check($sformatf("r%0d_math_timeout_delay", idx), err_t - en_t, TMO);
        if (v.exp_code == 2'b01)
            check($sformatf("r%0d_meas_timeout_delay", idx), err_t - sweep_t, TMO);
        if (sw2_t >= 0 && v.exp_moves > 0)
            check($sformatf("r%0d_settle_gap", idx), sw2_t - move_fall_t, SETTLE);
        model_orient = v.exp_orient;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sweep_req"}, sweep_req, 0);
        check({tag, "_move_fwd"}, move_fwd, 0);
        check({tag, "_math_enable"}, math_enable, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_orientation"}, orientation, 0);
        check({tag, "_orient_valid"}, orientation_valid, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_error_code"}, error_code, 0);
        check({tag, "_rt_original"}, math_r_theta_original, 0);
        check({tag, "_rt_final"}, math_r_theta_final, 0);
        check({tag, "_state"}, state_dbg, S_IDLE);
    endtask

    // ---------------- main sequence ----------------
    vec_t tbl[11];

    initial begin
        tbl[0]  = mk(12'h13A, 0,   12'h343, 2,   3,     5'd7,  0, 0, 2'b00, 5'd7,  1, MOVE, 1);
        tbl[1]  = mk(12'h122, 5,   12'h35D, 0,   0,     5'd4,  0, 0, 2'b00, 5'd4,  1, MOVE, 1);
        tbl[2]  = mk(12'hB25, 19,  12'h725, 19,  19,    5'd9,  0, 0, 2'b00, 5'd9,  1, MOVE, 1);
        tbl[3]  = mk(12'h110, 1,   12'h110, 1,   3,     5'd5,  0, 1, 2'b11, 5'd9,  0, MOVE, 0);
        tbl[4]  = mk(12'h2AB, 20,  12'h3CD, 0,   3,     5'd5,  0, 1, 2'b01, 5'd9,  0, 0,    0);
        tbl[5]  = mk(12'h2AB, 3,   12'h3CD, 20,  0,     5'd5,  0, 1, 2'b01, 5'd9,  0, MOVE, 0);
        tbl[6]  = mk(12'h0F1, 0,   12'h1F0, 0,   NEVER, 5'd5,  0, 1, 2'b10, 5'd9,  0, MOVE, 1);
        tbl[7]  = mk(12'h0F1, 0,   12'h1F0, 0,   20,    5'd6,  0, 1, 2'b10, 5'd9,  0, MOVE, 1);
        tbl[8]  = mk(12'h0F1, 0,   12'h1F0, 0,   19,    5'd6,  0, 0, 2'b00, 5'd6,  1, MOVE, 1);
        tbl[9]  = mk(12'h045, 2,   12'h067, 1,   4,     5'd11, 1, 0, 2'b00, 5'd11, 1, MOVE, 1);
        tbl[10] = mk(12'h045, 2,   12'h067, 1,   4,     5'd12, 2, 0, 2'b00, 5'd11, 0, MOVE, 0);

        reset_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) run_case(i, tbl[i]);

        for (int i = 0; i < 24; i++) begin
            vec_t v;
            v.v0   = 12'($urandom);
            v.v1   = ($urandom_range(0, 4) == 0) ? v.v0 : 12'($urandom);
            v.d0   = pick_delay();
            v.d1   = pick_delay();
            case ($urandom_range(0, 9))
                0:       v.lat = TMO - 1;
                1:       v.lat = TMO;
                2:       v.lat = NEVER;
                default: v.lat = $urandom_range(0, 8);
            endcase
            v.ret  = 5'($urandom_range(0, 23));
            v.mode = 0;
            run_case(100 + i, model(v));
        end

        // Reset in the middle of MOVE: everything drops before the next edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        drive_loc(12'h0A1, 0);
        for (int t = 0; t < 10 && !move_fwd; t++) tick();
        check("mid_move_reached", move_fwd, 1);
        tick();
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        reset_n = 1'b1;
        tick();
        model_orient = '0;

        begin
            vec_t v;
            v = mk(12'h3A7, 1, 12'h5B2, 2, 2, 5'd17, 0, 0, 0, 0, 0, 0, 0);
            run_case(200, model(v));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
